hdmi_tx_cfg_sequencer: RTL and testbench
========================================

# hdmi_tx_cfg_sequencer

Sequences the HDMI transmitter's register configuration over I2C. After power-up it waits a fixed settle time, then walks a table of (register, value) pairs and hands each pair to the existing byte-level I2C write master, retrying on NACK. It re-runs the full table whenever the transmitter raises its interrupt, for example on hot-plug. It sits between the top-level HDMI output block and the I2C master, replacing the free-running configuration logic.

## Interface

Parameters:
- DEV_ADDR, 8'h72: 8-bit I2C write address of the transmitter.
- NUM_REGS, 32: number of table entries; minimum 1.
- POWERUP_WAIT, 10_000_000: settle cycles after reset (200 ms at 50 MHz).
- MAX_RETRY, 3: attempts per entry before failing.

Ports:
- clock_50  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_int_n  in  1  transmitter interrupt (HDMI_TX_INT), active-low, asynchronous to clock_50.
- cmd_valid  out  1  write command valid to the I2C master.
- cmd_ready  in  1  I2C master accepts the command.
- cmd_dev  out  8  device address; constant DEV_ADDR.
- cmd_reg  out  8  register address of the current entry.
- cmd_data  out  8  value of the current entry.
- xfer_done  in  1  one-cycle pulse: the accepted transfer finished.
- xfer_nack  in  1  qualified by xfer_done; 1 means the transfer was NACKed.
- config_done  out  1  full table written with no failure.
- config_error  out  1  an entry exhausted its retries.
- pass_count  out  8  completed table passes; wraps from 255 to 0.

## Operation

- tx_int_n passes through a 2-flop synchronizer. A synchronized falling edge is an interrupt event.
- States:
  - POWERUP: down-counter loads POWERUP_WAIT−1 and counts to 0, then goes to ISSUE with idx=0 and retry=0.
  - ISSUE: cmd_valid=1. On cmd_valid&&cmd_ready, go to WAIT.
  - WAIT: hold until xfer_done.
    - NACK with retry<MAX_RETRY−1: increment retry, return to ISSUE with the same idx.
    - NACK with retry=MAX_RETRY−1: go to FAIL.
    - ACK with idx=NUM_REGS−1: go to DONE and increment pass_count.
    - ACK otherwise: increment idx, clear retry, go to ISSUE.
  - DONE: config_done=1. An interrupt event clears config_done and goes to ISSUE with idx=0 and retry=0.
  - FAIL: config_error=1. An interrupt event clears config_error and restarts as from DONE. Otherwise FAIL holds until reset.
- Interrupt events in POWERUP, ISSUE or WAIT set int_pending. A pass is never aborted mid-transfer.
- On entering DONE with int_pending set: config_done pulses for one cycle, int_pending clears, and the table restarts.
- Entering FAIL clears int_pending.
- Table entry 0 is register 8'h96 value 8'hFF, which clears the transmitter's interrupt status. Remaining entries are the power-up and 640x480p60 RGB-444 setup.
- xfer_done outside WAIT is ignored.

## Timing

- Reset values:
  - cmd_valid, config_done, config_error: 0.
  - pass_count: 0.
  - cmd_reg, cmd_data: entry 0.
  - State: POWERUP. idx, retry and int_pending: 0.
- All outputs are registered.
- cmd_valid, cmd_reg and cmd_data stay stable from cmd_valid's assertion until the handshake cycle. cmd_valid deasserts the cycle after cmd_ready is sampled high.
- First cmd_valid rises POWERUP_WAIT+1 cycles after reset_n deasserts.
- Back-to-back entries: ISSUE re-asserts cmd_valid the cycle after xfer_done.
- Interrupt latency: 2 synchronizer cycles plus 1 edge-detect cycle, then the state change.
- An interrupt edge in the same cycle as the final xfer_done is treated as pending: config_done pulses once, then the table restarts.
- pass_count increments on the DONE entry cycle only.
- idx width is $clog2(NUM_REGS), minimum 1. retry width is $clog2(MAX_RETRY+1).
- reset_n asserted mid-transfer drops cmd_valid immediately. The I2C master is on the same reset.

## Structure

- Shared package hdmi_tx_pkg holds:
  - the state enum;
  - HDMI_TX_I2C_ADDR = 8'h72 and HDMI_TX_INT_CLR_REG = 8'h96;
  - the cfg_entry_t {reg, data} 16-bit typedef.
- Sub-module hdmi_tx_cfg_rom: combinational idx → cfg_entry_t table, NUM_REGS entries. The sequencer registers its output into cmd_reg and cmd_data.
- The synchronizer is inline logic, not a separate module.

## Test plan

- Reset, POWERUP_WAIT=10, NUM_REGS=4, master always ACKs:
  - first cmd_valid at cycle 11 with cmd_reg=8'h96, cmd_data=8'hFF;
  - four transfers in table order;
  - then config_done=1 and pass_count=1.
- cmd_ready held low for 20 cycles: cmd_valid and fields stay constant all 20 cycles, then the handshake completes and cmd_valid drops the next cycle.
- Entry 2 NACKed twice, then ACKed, with MAX_RETRY=3: entry 2 issued three times and config_done=1. With three NACKs: config_error=1, no entry 3 issued, FAIL holds.
- In DONE, tx_int_n pulled low:
  - config_done drops within 4 cycles;
  - the pass restarts at entry 0 and completes;
  - pass_count=2.
- tx_int_n falls during entry 1's WAIT: the current pass finishes, config_done pulses one cycle, the table restarts, and pass_count=2 after the second pass.
- reset_n asserted while in WAIT: cmd_valid=0 and all outputs at reset values in the same cycle, and the sequence restarts from POWERUP.

Source files
------------

// File: rtl/hdmi_tx_pkg.sv
// hdmi_tx_pkg: shared types and constants for the HDMI transmitter configuration path.
//   state_t     - sequencer states
//   cfg_entry_t - one (register, value) table entry
package hdmi_tx_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [7:0] HDMI_TX_I2C_ADDR    = 8'h72;
   localparam logic [7:0] HDMI_TX_INT_CLR_REG = 8'h96;
   localparam logic [7:0] HDMI_TX_INT_CLR_VAL = 8'hFF;

   // "reg" is a keyword, so the register-address field is reg_addr
   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] data;
   } cfg_entry_t;

endpackage

// File: rtl/hdmi_tx_cfg_rom.sv
// hdmi_tx_cfg_rom: combinational configuration table, index -> (register, value).
//   i_idx   in  IW  table index
//   o_entry out 16  cfg_entry_t for that index
// Entry 0 clears the interrupt status; the rest power the transmitter up and
// set it for 640x480p60, RGB 4:4:4, HDMI mode.
module hdmi_tx_cfg_rom
   import hdmi_tx_pkg::*;
#(
   parameter int IW = 5
)(
   input  logic [IW-1:0] i_idx,
   output cfg_entry_t    o_entry
);

   always_comb begin
      o_entry = {HDMI_TX_INT_CLR_REG, HDMI_TX_INT_CLR_VAL};
      case (int'(i_idx))
         1:  o_entry = 16'h4110;  // power up
         2:  o_entry = 16'h9803;  // fixed registers
         3:  o_entry = 16'h9AE0;
         4:  o_entry = 16'h9C30;
         5:  o_entry = 16'h9D61;
         6:  o_entry = 16'hA2A4;
         7:  o_entry = 16'hA3A4;
         8:  o_entry = 16'hE0D0;
         9:  o_entry = 16'hF900;
         10: o_entry = 16'h1500;  // input ID 0, 4:4:4
         11: o_entry = 16'h1630;  // 8 bit per colour
         12: o_entry = 16'h1700;  // 4:3 aspect, normal syncs
         13: o_entry = 16'h1846;  // colour-space converter off
         14: o_entry = 16'hAF06;  // HDMI mode
         15: o_entry = 16'h4080;  // general control packet enable
         16: o_entry = 16'h4C04;  // 24-bit colour depth
         17: o_entry = 16'h5500;  // AVI: RGB
         18: o_entry = 16'h5618;  // AVI: 4:3 picture aspect
         19: o_entry = 16'h3C01;  // VIC 1, 640x480p60
         20: o_entry = 16'h3B00;  // pixel repetition auto
         21: o_entry = 16'h9480;  // HPD interrupt enable
         22: o_entry = 16'h9500;
         23: o_entry = 16'hD03C;  // sync polarity handling
         24: o_entry = 16'hBA60;  // no clock delay
         25: o_entry = 16'hD6C0;  // HPD always high
         26: o_entry = 16'h0100;  // audio N value
         27: o_entry = 16'h0218;
         28: o_entry = 16'h0300;
         29: o_entry = 16'h0A01;
         30: o_entry = 16'h0C84;
         31: o_entry = 16'h4A80;  // auto checksum
         default: ;
      endcase
   end

endmodule

// File: rtl/hdmi_tx_cfg_sequencer.sv
// hdmi_tx_cfg_sequencer: waits after power-up, then writes the configuration
// table through the byte-level I2C write master, retrying NACKed entries and
// re-running the table on every transmitter interrupt.
//   clock_50     in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   tx_int_n     in   1  transmitter interrupt, active-low, asynchronous
//   cmd_valid    out  1  write command valid
//   cmd_ready    in   1  master accepts command
//   cmd_dev      out  8  device address (DEV_ADDR)
//   cmd_reg      out  8  register address of current entry
//   cmd_data     out  8  value of current entry
//   xfer_done    in   1  accepted transfer finished (pulse)
//   xfer_nack    in   1  transfer NACKed, qualified by xfer_done
//   config_done  out  1  table written without failure
//   config_error out  1  an entry ran out of retries
//   pass_count   out  8  completed table passes, wrapping
module hdmi_tx_cfg_sequencer
   import hdmi_tx_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR     = HDMI_TX_I2C_ADDR,
   parameter int         NUM_REGS     = 32,
   parameter int         POWERUP_WAIT = 10_000_000,
   parameter int         MAX_RETRY    = 3
)(
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic       tx_int_n,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_dev,
   output logic [7:0] cmd_reg,
   output logic [7:0] cmd_data,
   input  logic       xfer_done,
   input  logic       xfer_nack,
   output logic       config_done,
   output logic       config_error,
   output logic [7:0] pass_count
);

   localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int CW = POWERUP_WAIT > 1 ? $clog2(POWERUP_WAIT) : 1;
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REGS - 1);
   localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRY - 1);

   state_t          r_state, w_state;
   logic [CW-1:0]   r_cnt;
   logic [IW-1:0]   r_idx, w_idx;
   logic [RW-1:0]   r_retry, w_retry;
   logic            r_pend, w_pend;
   logic [1:0]      r_sync;
   logic            r_int_d, r_int_evt;
   logic            r_cmd_valid, r_done, r_error;
   logic [7:0]      r_cmd_reg, r_cmd_data, r_pass;
   cfg_entry_t      w_entry;

   // Fields are loaded from the next index so they are valid together with cmd_valid
   hdmi_tx_cfg_rom #(.IW(IW)) u_rom (
      .i_idx   (w_idx),
      .o_entry (w_entry)
   );

   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_retry = r_retry;
      // events that arrive mid-pass are remembered and honoured at DONE
      w_pend  = r_pend | (r_int_evt & (r_state inside {ST_POWERUP, ST_ISSUE, ST_WAIT}));
      case (r_state)
         ST_POWERUP: if (r_cnt == '0) begin
            w_state = ST_ISSUE;
            w_idx   = '0;
            w_retry = '0;
         end
         ST_ISSUE: if (cmd_ready) w_state = ST_WAIT;
         ST_WAIT: if (xfer_done) begin
            if (xfer_nack) begin
               if (r_retry == LAST_RETRY) begin
                  w_state = ST_FAIL;
                  w_pend  = 1'b0;
               end else begin
                  w_retry = r_retry + 1'b1;
                  w_state = ST_ISSUE;
               end
            end else if (r_idx == LAST_IDX) begin
               w_state = ST_DONE;
            end else begin
               w_idx   = r_idx + 1'b1;
               w_retry = '0;
               w_state = ST_ISSUE;
            end
         end
         ST_DONE, ST_FAIL: if (r_pend | r_int_evt) begin
            w_state = ST_ISSUE;
            w_idx   = '0;
            w_retry = '0;
            w_pend  = 1'b0;
         end
         default: w_state = ST_POWERUP;
      endcase
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_POWERUP;
         r_cnt       <= CW'(POWERUP_WAIT - 1);
         r_idx       <= '0;
         r_retry     <= '0;
         r_pend      <= 1'b0;
         r_sync      <= 2'b11;
         r_int_d     <= 1'b1;
         r_int_evt   <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd_reg   <= HDMI_TX_INT_CLR_REG;
         r_cmd_data  <= HDMI_TX_INT_CLR_VAL;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_pass      <= '0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= (r_state == ST_POWERUP && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
         r_idx       <= w_idx;
         r_retry     <= w_retry;
         r_pend      <= w_pend;
         r_sync      <= {r_sync[0], tx_int_n};
         r_int_d     <= r_sync[1];
         r_int_evt   <= r_int_d & ~r_sync[1];
         r_cmd_valid <= w_state == ST_ISSUE;
         r_cmd_reg   <= w_entry.reg_addr;
         r_cmd_data  <= w_entry.data;
         r_done      <= w_state == ST_DONE;
         r_error     <= w_state == ST_FAIL;
         r_pass      <= (w_state == ST_DONE && r_state != ST_DONE) ? r_pass + 1'b1 : r_pass;
      end
   end

   assign cmd_valid    = r_cmd_valid;
   assign cmd_dev      = DEV_ADDR;
   assign cmd_reg      = r_cmd_reg;
   assign cmd_data     = r_cmd_data;
   assign config_done  = r_done;
   assign config_error = r_error;
   assign pass_count   = r_pass;

endmodule

// File: tb/tb_hdmi_tx_cfg_sequencer.sv
// tb_hdmi_tx_cfg_sequencer: directed bench with a behavioural I2C write master.
module tb_hdmi_tx_cfg_sequencer;

   logic       clock_50 = 1'b0;
   logic       reset_n  = 1'b0;
   logic       tx_int_n = 1'b1;
   logic       cmd_valid, cmd_ready, xfer_done, xfer_nack;
   logic [7:0] cmd_dev, cmd_reg, cmd_data, pass_count;
   logic       config_done, config_error;

   int         n_chk = 0, n_err = 0;
   logic [7:0] q[$];
   int         hold_req = 0, held = 0, busy = 0, nack_n = 0;
   logic [7:0] nack_reg = 8'h00, cap_reg = 8'h00;

   always #5 clock_50 = ~clock_50;

   hdmi_tx_cfg_sequencer #(
      .DEV_ADDR     (8'h72),
      .NUM_REGS     (4),
      .POWERUP_WAIT (10),
      .MAX_RETRY    (3)
   ) dut (
      .clock_50     (clock_50),
      .reset_n      (reset_n),
      .tx_int_n     (tx_int_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_dev      (cmd_dev),
      .cmd_reg      (cmd_reg),
      .cmd_data     (cmd_data),
      .xfer_done    (xfer_done),
      .xfer_nack    (xfer_nack),
      .config_done  (config_done),
      .config_error (config_error),
      .pass_count   (pass_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // I2C master model: optional ready stall, 3-cycle transfer, NACKs a chosen register nack_n times
   initial begin
      cmd_ready = 1'b0;
      xfer_done = 1'b0;
      xfer_nack = 1'b0;
      forever begin
         @(negedge clock_50);
         xfer_done = 1'b0;
         xfer_nack = 1'b0;
         if (!reset_n) begin
            cmd_ready = 1'b0;
            busy = 0;
            held = 0;
         end else if (cmd_ready) begin
            cmd_ready = 1'b0;
            q.push_back(cap_reg);
            busy = 3;
            held = 0;
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               xfer_done = 1'b1;
               if (cap_reg == nack_reg && nack_n > 0) begin
                  xfer_nack = 1'b1;
                  nack_n--;
               end
            end
         end else if (cmd_valid) begin
            if (held < hold_req) held++;
            else begin
               cmd_ready = 1'b1;
               cap_reg = cmd_reg;
            end
         end
      end
   end

   task automatic release_and_first_valid(output int cyc);
      @(negedge clock_50);
      reset_n = 1'b1;
      cyc = 1;
      for (int i = 0; i < 100 && !cmd_valid; i++) begin
         @(posedge clock_50);
         #1;
         cyc++;
      end
   endtask

   task automatic wait_end();
      for (int i = 0; i < 500 && !(config_done || config_error); i++) begin
         @(posedge clock_50);
         #1;
      end
   endtask

   task automatic run_pass();
      q.delete();
      @(negedge clock_50);
      tx_int_n = 1'b0;
      repeat (6) @(negedge clock_50);
      tx_int_n = 1'b1;
      wait_end();
   endtask

   task automatic wait_q(input int n);
      for (int i = 0; i < 200 && q.size() < n; i++) begin
         @(posedge clock_50);
         #1;
      end
   endtask

   initial begin
      int cyc, lat, pulses;
      logic [7:0] r0, d0;
      logic stable;
      repeat (3) @(negedge clock_50);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_done", config_done, 0);
      chk("rst_error", config_error, 0);
      chk("rst_pass", pass_count, 0);
      chk("rst_reg", cmd_reg, 8'h96);
      chk("rst_data", cmd_data, 8'hFF);
      chk("dev", cmd_dev, 8'h72);

      release_and_first_valid(cyc);
      chk("first_valid_cycle", cyc, 11);
      chk("first_reg", cmd_reg, 8'h96);
      chk("first_data", cmd_data, 8'hFF);
      wait_end();
      chk("p1_done", config_done, 1);
      chk("p1_pass", pass_count, 1);
      chk("p1_nxfer", q.size(), 4);
      chk("p1_e0", q[0], 8'h96);
      chk("p1_e1", q[1], 8'h41);
      chk("p1_e2", q[2], 8'h98);
      chk("p1_e3", q[3], 8'h9A);

      // interrupt in DONE with a stalled master
      q.delete();
      hold_req = 20;
      @(negedge clock_50);
      tx_int_n = 1'b0;
      lat = 0;
      for (int i = 0; i < 10 && config_done; i++) begin
         @(posedge clock_50);
         #1;
         lat++;
      end
      chk("int_latency_le4", lat <= 4, 1);
      chk("int_restart_valid", cmd_valid, 1);
      chk("int_restart_reg", cmd_reg, 8'h96);
      r0 = cmd_reg;
      d0 = cmd_data;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clock_50);
         if (!cmd_valid || cmd_reg != r0 || cmd_data != d0) stable = 1'b0;
      end
      chk("stall_stable", stable, 1);
      hold_req = 0;
      tx_int_n = 1'b1;
      @(negedge clock_50);
      @(posedge clock_50);
      #1;
      chk("stall_drop", cmd_valid, 0);
      wait_end();
      chk("p2_done", config_done, 1);
      chk("p2_pass", pass_count, 2);
      chk("p2_nxfer", q.size(), 4);
      chk("p2_e0", q[0], 8'h96);

      // entry 2 NACKed twice then ACKed
      nack_reg = 8'h98;
      nack_n = 2;
      run_pass();
      chk("n2_done", config_done, 1);
      chk("n2_error", config_error, 0);
      chk("n2_nxfer", q.size(), 6);
      chk("n2_e4", q[4], 8'h98);
      chk("n2_e5", q[5], 8'h9A);
      chk("n2_pass", pass_count, 3);

      // entry 2 NACKed three times: FAIL
      nack_n = 3;
      run_pass();
      chk("n3_error", config_error, 1);
      chk("n3_done", config_done, 0);
      chk("n3_nxfer", q.size(), 5);
      chk("n3_e4", q[4], 8'h98);
      repeat (20) @(posedge clock_50);
      #1;
      chk("fail_hold_error", config_error, 1);
      chk("fail_hold_valid", cmd_valid, 0);
      chk("fail_hold_nxfer", q.size(), 5);
      chk("fail_hold_pass", pass_count, 3);

      // interrupt restarts from FAIL
      nack_n = 0;
      run_pass();
      chk("frs_done", config_done, 1);
      chk("frs_error", config_error, 0);
      chk("frs_pass", pass_count, 4);
      chk("frs_nxfer", q.size(), 4);

      // reset while entry 1 is in WAIT
      q.delete();
      @(negedge clock_50);
      tx_int_n = 1'b0;
      wait_q(2);
      chk("rw_in_wait", cmd_valid, 0);
      reset_n = 1'b0;
      #1;
      chk("rw_valid", cmd_valid, 0);
      chk("rw_done", config_done, 0);
      chk("rw_error", config_error, 0);
      chk("rw_pass", pass_count, 0);
      chk("rw_reg", cmd_reg, 8'h96);
      chk("rw_data", cmd_data, 8'hFF);
      tx_int_n = 1'b1;
      @(negedge clock_50);
      q.delete();
      release_and_first_valid(cyc);
      chk("rw_first_valid_cycle", cyc, 11);

      // interrupt during entry 1's WAIT of the first pass
      wait_q(2);
      tx_int_n = 1'b0;
      pulses = 0;
      for (int i = 0; i < 500 && !(q.size() >= 8 && config_done); i++) begin
         @(posedge clock_50);
         #1;
         if (config_done && q.size() < 8) pulses++;
      end
      tx_int_n = 1'b1;
      chk("mid_pulse_cycles", pulses, 1);
      chk("mid_nxfer", q.size(), 8);
      chk("mid_restart_e4", q[4], 8'h96);
      chk("mid_e7", q[7], 8'h9A);
      chk("mid_done", config_done, 1);
      chk("mid_pass", pass_count, 2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
